// File: rtl/fmul_operand_feeder_if.sv
// Stream and multiplier-side handshake bundle for the float32 multiplier operand feeder.
// The master modport is the feeder itself; the slave modport is its environment.
interface fmul_operand_feeder_if;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;

    modport master (
        input  in_a, in_b, in_valid, input_a_ack, input_b_ack,
        output in_ready, input_a, input_a_stb, input_b, input_b_stb
    );

    modport slave (
        output in_a, in_b, in_valid, input_a_ack, input_b_ack,
        input  in_ready, input_a, input_a_stb, input_b, input_b_stb
    );
endinterface

// File: rtl/fmul_operand_feeder.sv
// Buffers (a,b) operand pairs in a FIFO and replays each pair to the float32 multiplier
// over its serial stb/ack handshake: input_a first, then input_b.
module fmul_operand_feeder #(
    parameter int  DEPTH = 4,
    parameter int  CNT_W = 16,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fmul_operand_feeder_if.master bus,
    output logic [PTR_W-1:0]     count,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic                 busy
);
    localparam int              AW         = PTR_W - 1;
    localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    logic [63:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] count_r;
    state_t           state_r;
    state_t           state_s;
    logic [31:0]      input_a_r;
    logic [31:0]      input_a_s;
    logic [31:0]      input_b_r;
    logic [31:0]      input_b_s;
    logic             a_stb_r;
    logic             a_stb_s;
    logic             b_stb_r;
    logic             b_stb_s;
    logic [CNT_W-1:0] issued_r;
    logic [CNT_W-1:0] issued_s;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic [63:0]      head_s;

    // in_ready looks only at the registered count, so a same-cycle pop never frees a full FIFO.
    assign bus.in_ready = (count_r != FULL_COUNT);
    assign push_s       = bus.in_valid & bus.in_ready;
    assign pop_s        = (state_r == SEND_B) & bus.input_b_ack;
    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];

    assign bus.input_a     = input_a_r;
    assign bus.input_b     = input_b_r;
    assign bus.input_a_stb = a_stb_r;
    assign bus.input_b_stb = b_stb_r;
    assign count           = count_r;
    assign issued_cnt      = issued_r;
    assign busy            = (state_r != IDLE) | (count_r != {PTR_W{1'b0}});

    // Operand storage; contents are don't-care until written, pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + PTR_W'(1);
                2'b01:   count_r <= count_r - PTR_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Handshake sequencer next-state and output decode.
    always_comb begin
        state_s   = state_r;
        input_a_s = input_a_r;
        input_b_s = input_b_r;
        a_stb_s   = a_stb_r;
        b_stb_s   = b_stb_r;
        issued_s  = issued_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_s   = SEND_A;
                    a_stb_s   = 1'b1;
                    input_a_s = head_s[63:32];
                    input_b_s = head_s[31:0];
                end else begin
                    state_s = IDLE;
                end
            end
            SEND_A: begin
                if (bus.input_a_ack) begin
                    state_s = SEND_B;
                    a_stb_s = 1'b0;
                    b_stb_s = 1'b1;
                end else begin
                    state_s = SEND_A;
                end
            end
            SEND_B: begin
                if (bus.input_b_ack) begin
                    state_s  = IDLE;
                    b_stb_s  = 1'b0;
                    issued_s = issued_r + CNT_W'(1);
                end else begin
                    state_s = SEND_B;
                end
            end
            default: begin
                state_s = IDLE;
                a_stb_s = 1'b0;
                b_stb_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered multiplier-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            input_a_r <= 32'h0000_0000;
            input_b_r <= 32'h0000_0000;
            a_stb_r   <= 1'b0;
            b_stb_r   <= 1'b0;
            issued_r  <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            input_a_r <= input_a_s;
            input_b_r <= input_b_s;
            a_stb_r   <= a_stb_s;
            b_stb_r   <= b_stb_s;
            issued_r  <= issued_s;
        end
    end
endmodule

// File: tb/tb_fmul_operand_feeder.sv
// Scoreboard bench for fmul_operand_feeder: the driver queues accepted pairs, a monitor
// pops and checks them at every multiplier handshake.
module tb_fmul_operand_feeder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmul_operand_feeder_if bus();
    logic [PTR_W-1:0] count;
    logic [CNT_W-1:0] issued_cnt;
    logic             busy;

    fmul_operand_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count      (count),
        .issued_cnt (issued_cnt),
        .busy       (busy)
    );

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic [63:0]      exp_q[$];
    int               a_times[$];
    logic [CNT_W-1:0] exp_issued = 4'd0;

    logic [31:0] va [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'hBF800000, 32'h3F000000, 32'h7F800000, 32'h00000000};
    logic [31:0] vb [8] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'hC0000000, 32'h3E800000, 32'hFF800000, 32'h80000000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input int budget);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({a, b});
                done = 1'b1;
            end else if (n >= budget) begin
                checks++;
                errors++;
                $display("FAIL push_timeout actual=not_accepted required=accepted a=%0h", a);
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(busy), 64'd0);
        check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: checks every multiplier handshake against the head of the scoreboard.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("stb_exclusive", 64'(bus.input_a_stb & bus.input_b_stb), 64'd0);
                if (bus.input_a_stb && bus.input_a_ack) begin
                    a_times.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_issue actual=%0h required=no_issue", bus.input_a);
                    end else begin
                        check("a_data", 64'(bus.input_a), 64'(exp_q[0][63:32]));
                    end
                end
                if (bus.input_b_stb && bus.input_b_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_issue actual=%0h required=no_issue", bus.input_b);
                    end else begin
                        e = exp_q.pop_front();
                        check("b_data", 64'(bus.input_b), 64'(e[31:0]));
                        check("a_hold", 64'(bus.input_a), 64'(e[63:32]));
                    end
                    exp_issued = exp_issued + 4'd1;
                    @(posedge clk);
                    #1;
                    check("issued_cnt", 64'(issued_cnt), 64'(exp_issued));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.in_a = 32'd0;
        bus.in_b = 32'd0;
        bus.in_valid = 1'b0;
        bus.input_a_ack = 1'b0;
        bus.input_b_ack = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_a_stb", 64'(bus.input_a_stb), 64'd0);
        check("rst_b_stb", 64'(bus.input_b_stb), 64'd0);
        check("rst_input_a", 64'(bus.input_a), 64'd0);
        check("rst_input_b", 64'(bus.input_b), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_issued", 64'(issued_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Single pair with A-ack delayed three cycles
        push_pair(32'h3F800000, 32'h40000000, 4);
        check("lat_n1_a_stb", 64'(bus.input_a_stb), 64'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("hold_a_stb", 64'(bus.input_a_stb), 64'd1);
            check("hold_input_a", 64'(bus.input_a), 64'h3F800000);
            step();
        end
        bus.input_a_ack = 1'b1;
        step();
        bus.input_a_ack = 1'b0;
        check("t2_a_stb_drop", 64'(bus.input_a_stb), 64'd0);
        check("t2_b_stb", 64'(bus.input_b_stb), 64'd1);
        check("t2_input_b", 64'(bus.input_b), 64'h40000000);
        bus.input_b_ack = 1'b1;
        step();
        bus.input_b_ack = 1'b0;
        check("t2_b_stb_drop", 64'(bus.input_b_stb), 64'd0);
        check("t2_issued", 64'(issued_cnt), 64'd1);
        check("t2_count", 64'(count), 64'd0);
        check("t2_busy", 64'(busy), 64'd0);

        // Fill with acks low; fifth pair refused
        for (int i = 0; i < 4; i++) push_pair(va[i], vb[i], 4);
        check("t3_count_full", 64'(count), 64'd4);
        check("t3_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_a = va[4];
        bus.in_b = vb[4];
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_fifth_refused", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("t3_count_held", 64'(count), 64'd4);
        bus.input_a_ack = 1'b1;
        bus.input_b_ack = 1'b1;
        wait_idle(60, "t3_drain");
        check("t3_issued", 64'(issued_cnt), 64'd5);

        // Pop coincident with push at full, then at count 2
        bus.input_a_ack = 1'b0;
        bus.input_b_ack = 1'b0;
        for (int i = 4; i < 8; i++) push_pair(va[i], vb[i], 4);
        check("t4_in_send_a", 64'(bus.input_a_stb), 64'd1);
        bus.input_a_ack = 1'b1;
        step();
        bus.input_a_ack = 1'b0;
        bus.input_b_ack = 1'b1;
        bus.in_a = 32'hDEAD0001;
        bus.in_b = 32'hDEAD0002;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("t4_full_pop_ready", 64'(bus.in_ready), 64'd0);
        check("t4_full_pop_count", 64'(count), 64'd4);
        @(posedge clk);
        #1;
        bus.input_b_ack = 1'b0;
        bus.in_valid = 1'b0;
        check("t4_count3", 64'(count), 64'd3);
        check("t4_ready3", 64'(bus.in_ready), 64'd1);
        bus.input_a_ack = 1'b1;
        step();
        step();
        bus.input_a_ack = 1'b0;
        bus.input_b_ack = 1'b1;
        step();
        bus.input_b_ack = 1'b0;
        check("t4_count2", 64'(count), 64'd2);
        bus.input_a_ack = 1'b1;
        step();
        step();
        bus.input_a_ack = 1'b0;
        check("t4_send_b_again", 64'(bus.input_b_stb), 64'd1);
        bus.input_b_ack = 1'b1;
        bus.in_a = 32'h41200000;
        bus.in_b = 32'h41300000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("t4_push_pop_ready", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) exp_q.push_back({32'h41200000, 32'h41300000});
        @(posedge clk);
        #1;
        bus.input_b_ack = 1'b0;
        bus.in_valid = 1'b0;
        check("t4_push_pop_count", 64'(count), 64'd2);
        bus.input_a_ack = 1'b1;
        bus.input_b_ack = 1'b1;
        wait_idle(60, "t4_drain");
        check("t4_issued", 64'(issued_cnt), 64'd10);

        // Streaming with acks high: one A strobe every third cycle
        a_times.delete();
        for (int i = 0; i < 8; i++) push_pair(vb[i], va[i], 10);
        wait_idle(60, "t5_drain");
        check("t5_a_count", 64'(a_times.size()), 64'd8);
        for (int i = 1; i < a_times.size(); i++) begin
            check("t5_a_period", 64'(a_times[i] - a_times[i-1]), 64'd3);
        end
        check("t5_issued", 64'(issued_cnt), 64'd2);

        // Reset in the middle of buffered and in-flight work
        bus.input_a_ack = 1'b0;
        bus.input_b_ack = 1'b0;
        for (int i = 0; i < 3; i++) push_pair(va[i], vb[i], 4);
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_a_stb", 64'(bus.input_a_stb), 64'd0);
        check("mid_rst_b_stb", 64'(bus.input_b_stb), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_issued", 64'(issued_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        exp_issued = 4'd0;
        step();
        rst = 1'b1;
        repeat (3) step();
        check("post_rst_a_stb", 64'(bus.input_a_stb), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Counter wrap
        bus.input_a_ack = 1'b1;
        bus.input_b_ack = 1'b1;
        for (int i = 0; i < 15; i++) push_pair({16'hA5A5, 16'(i)}, {16'h5A5A, 16'(i)}, 10);
        wait_idle(80, "t6_drain");
        check("t6_issued_max", 64'(issued_cnt), 64'hF);
        push_pair(32'h3F800000, 32'h3F800000, 4);
        wait_idle(20, "t6_wrap_drain");
        check("t6_issued_wrap", 64'(issued_cnt), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
